sync_data_fifo: RTL and testbench
=================================

// Module: sync_data_fifo
// PURPOSE
//   Parametrised single-clock FIFO for pipeline data buffering: fetch-to-decode instruction queue, LSU data staging.
//   Generalises the one-deep buffer. Adds configurable depth, protected handshakes and an occupancy count.
//   Adds almost-full/will-full flags, optional first-word-fall-through read mode, flush, and sticky overflow/underflow flags.
// PARAMETERS
//   DATA_WIDTH  64  payload width in bits
//   DEPTH       4   number of entries; power of two, >= 2
//   AF_THRESH   3   WAlmostFull asserts when Count >= AF_THRESH; 1 <= AF_THRESH <= DEPTH
//   FWFT        0   0 = registered read (data 1 cycle after RInc); 1 = first-word-fall-through
//   Derived: AW = $clog2(DEPTH); CW = AW+1
// PORTS
//   Clk          in   1           clock, all logic on posedge
//   Rst          in   1           synchronous reset, active-high
//   WData        in   DATA_WIDTH  write data
//   WInc         in   1           write request
//   WFull        out  1           FIFO full; write ignored
//   W_Will_Full  out  1           Count == DEPTH-1 (one free slot)
//   WAlmostFull  out  1           Count >= AF_THRESH
//   RData        out  DATA_WIDTH  read data (timing per FWFT)
//   RInc         in   1           read request / pop
//   REmpty       out  1           FIFO empty; read ignored
//   Jump         in   1           flush: discard all contents (branch redirect)
//   Count        out  CW          current occupancy, 0..DEPTH
//   Overflow     out  1           sticky: WInc seen while full
//   Underflow    out  1           sticky: RInc seen while empty
// BEHAVIOUR
//   Pointers: WrPtr/RdPtr are CW bits; low AW bits index memory; MSB is wrap bit.
//     Empty when WrPtr == RdPtr. Full when MSBs differ and low bits are equal. Count = WrPtr - RdPtr (mod 2^CW).
//   Write accepted: WInc && !WFull && !Jump. Mem[WrPtr[AW-1:0]] <= WData; WrPtr += 1.
//   Read accepted: RInc && !REmpty && !Jump. RdPtr += 1.
//   Flags derive from state at the start of the cycle:
//     full + WInc + RInc: read accepted, write rejected (Overflow set).
//     empty + WInc + RInc: write accepted, read rejected (Underflow set).
//   Other simultaneous W+R accepted together: Count unchanged.
//   FWFT=0: RData registered; loads Mem[RdPtr] on the cycle after an accepted read.
//     Otherwise RData holds. Unaffected by Jump.
//   FWFT=1: RData = Mem[RdPtr[AW-1:0]] combinationally. Valid whenever !REmpty. RInc pops.
//   Jump: highest priority below Rst. Next cycle WrPtr = RdPtr = 0, Count = 0, REmpty = 1.
//     WInc/RInc in the same cycle are dropped and do not set the sticky flags. Memory contents are not cleared.
//   Wrap: pointers wrap mod 2^CW naturally; no special case at DEPTH boundary.
//   Sticky flags: set on rejected requests (excluding Jump cycles). Cleared only by Rst.
//   Reset values (Rst=1 at posedge), regardless of in-flight traffic:
//     WrPtr=RdPtr=0, Count=0, REmpty=1, WFull=0, W_Will_Full=0, WAlmostFull=0, Overflow=0, Underflow=0.
//     RData=0 (FWFT=0). Memory not reset.
//   Outputs WFull/REmpty/Count/W_Will_Full/WAlmostFull are combinational from registered pointers; no comb path from WInc/RInc.
// STRUCTURE
//   Package fifo_pkg: fifo_ptr_t helpers, localparam functions ptr_full()/ptr_empty(), elaboration checks (DEPTH pow2, AF_THRESH range).
//   Sub-module fifo_ptr_ctrl: pointer regs, accept logic, flags, Count, sticky errors. Instantiated by sync_data_fifo.
//   Memory array and RData mux/register stay in the top module.
// TESTING
//   Fill/drain, DEPTH=4, FWFT=0: write 0xA0..0xA3.
//     -> WAlmostFull at Count=3, WFull at 4. Four reads return 0xA0..0xA3 one cycle after each RInc; REmpty=1 after the 4th.
//   Overflow: full, WInc with 0xFF -> Count stays 4, Overflow=1 sticky, 0xFF never read out.
//   Underflow: empty, RInc -> Underflow=1; RData holds last value; RdPtr unchanged.
//   Simultaneous: Count=2, WInc+RInc each cycle for 10 cycles -> Count stays 2, in-order data across pointer wrap.
//     Full + WInc + RInc -> Count=3.
//   Flush: Count=3, assert Jump with WInc=RInc=1 -> next cycle Count=0, REmpty=1, no sticky flag set.
//     Then write 0xB0 -> reads back 0xB0.
//   FWFT=1: write 0xC0 -> RData=0xC0 the cycle after the write, with no RInc. RInc pops; REmpty=1 next cycle.
//   Reset mid-traffic: Rst during writes at Count=2 -> all reset values next cycle.

Source files
------------

// File: rtl/sync_data_fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared helpers for the synchronous data FIFO.
//   - fifo_ptr_t : wide container for read/write pointers. Callers zero-extend
//                  their CW-bit pointers into it, so one set of helpers works
//                  for any depth.
//   - is_pow2()  : elaboration-time depth legality check.
//   - ptr_empty(): pointers identical, including the wrap bit.
//   - ptr_full() : wrap bits differ and the index bits match.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] fifo_ptr_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic logic ptr_empty(input fifo_ptr_t wr, input fifo_ptr_t rd);
    return wr == rd;
  endfunction

  // aw is the number of index bits; bit aw of each pointer is the wrap bit.
  function automatic logic ptr_full(input fifo_ptr_t wr, input fifo_ptr_t rd,
                                    input int aw);
    fifo_ptr_t diff;
    fifo_ptr_t low_mask;
    fifo_ptr_t wrap_mask;
    diff      = wr ^ rd;
    wrap_mask = fifo_ptr_t'(1) << aw;
    low_mask  = wrap_mask - fifo_ptr_t'(1);
    return ((diff & low_mask) == '0) && ((diff & wrap_mask) != '0);
  endfunction

endpackage

// File: rtl/sync_data_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_data_fifo_if
//   Write/read handshake bundle for sync_data_fifo.
//   master : producer/consumer side (drives wdata, winc, rinc, jump)
//   slave  : FIFO side (drives status flags, count and rdata)
//   Ports of the bundle:
//     wdata/winc           write data and request
//     wfull/will_full      full, exactly one free slot
//     almost_full          count >= almost-full threshold
//     rdata/rinc/rempty    read data, pop request, empty
//     jump                 flush all contents
//     count                occupancy 0..DEPTH
//     overflow/underflow   sticky rejected-request flags
// ---------------------------------------------------------------------------
interface sync_data_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] wdata;
  logic                  winc;
  logic                  wfull;
  logic                  will_full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  rempty;
  logic                  jump;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wdata, winc, rinc, jump,
    input  wfull, will_full, almost_full, rdata, rempty, count,
           overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, jump,
    output wfull, will_full, almost_full, rdata, rempty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_data_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Pointer registers, accept logic, status flags, occupancy and sticky
//   error flags for sync_data_fifo.
//   Inputs : clk, rst, winc, rinc, jump
//   Outputs: wr_addr/rd_addr (memory indices), wr_en/rd_en (accepted ops),
//            full, empty, will_full, almost_full, count, overflow, underflow
//   All status outputs are decoded from the registered pointers only, so there
//   is no combinational path from winc/rinc to any flag.
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AW        = $clog2(DEPTH),
  parameter int CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          winc,
  input  logic          rinc,
  input  logic          jump,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          wr_en,
  output logic          rd_en,
  output logic          full,
  output logic          empty,
  output logic          will_full,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;

  always_comb begin
    full        = ptr_full(fifo_ptr_t'(wr_ptr_reg), fifo_ptr_t'(rd_ptr_reg), AW);
    empty       = ptr_empty(fifo_ptr_t'(wr_ptr_reg), fifo_ptr_t'(rd_ptr_reg));
    // Modular subtraction gives the occupancy across pointer wrap.
    count       = wr_ptr_reg - rd_ptr_reg;
    will_full   = (count == CW'(DEPTH - 1));
    almost_full = (count >= CW'(AF_THRESH));
    wr_addr     = wr_ptr_reg[AW-1:0];
    rd_addr     = rd_ptr_reg[AW-1:0];

    // Flags come from the start-of-cycle state, so full+W+R pops only and
    // empty+W+R pushes only.
    wr_en = winc && !full  && !jump;
    rd_en = rinc && !empty && !jump;

    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (jump) begin
      // Flush drops same-cycle requests without flagging them.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + CW'(1);
      if (rd_en) rd_ptr_next = rd_ptr_reg + CW'(1);
      if (winc && full)  overflow_next  = 1'b1;
      if (rinc && empty) underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/sync_data_fifo.sv
// ---------------------------------------------------------------------------
// sync_data_fifo
//   Parametrised single-clock FIFO for pipeline buffering (instruction queue,
//   load/store data staging).
//   Ports:
//     clk  : clock, all logic on posedge
//     rst  : synchronous active-high reset
//     bus  : sync_data_fifo_if.slave (write/read handshake, flags, count,
//            flush, sticky overflow/underflow)
//   Parameters: DATA_WIDTH, DEPTH (power of two >= 2), AF_THRESH
//   (1..DEPTH), FWFT (0 = rdata registered on pop, 1 = head shown directly).
//   Storage is not reset; only the pointers, flags and rdata register are.
// ---------------------------------------------------------------------------
module sync_data_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = 3,
  parameter int FWFT       = 0
) (
  input  logic           clk,
  input  logic           rst,
  sync_data_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_data_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_data_fifo: AF_THRESH must be within 1..DEPTH");
  end

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          rd_en;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AW        (AW),
    .CW        (CW)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .winc        (bus.winc),
    .rinc        (bus.rinc),
    .jump        (bus.jump),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .full        (bus.wfull),
    .empty       (bus.rempty),
    .will_full   (bus.will_full),
    .almost_full (bus.almost_full),
    .count       (bus.count),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is visible whenever the FIFO is non-empty; rinc just pops.
    assign bus.rdata = mem[rd_addr];
  end else begin : g_reg_read
    // The popped entry lands in the register on the accepting edge; a write
    // into the same slot cannot coincide because that slot is not full-free.
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_reg <= '0;
      end else if (rd_en) begin
        rdata_reg <= mem[rd_addr];
      end
    end

    assign bus.rdata = rdata_reg;
  end

endmodule

// File: tb/tb_sync_data_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_data_fifo
//   Drives a registered-read FIFO (u_reg) and a first-word-fall-through FIFO
//   (u_fwft) with identical stimulus. A queue-based reference model tracks
//   contents, sticky flags and the registered read word.
// ---------------------------------------------------------------------------
module tb_sync_data_fifo;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_data_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  sync_data_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  sync_data_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .FWFT(0)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sync_data_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_udf;
  logic [DW-1:0] m_rdata;

  // Apply one cycle of stimulus to both FIFOs and advance the model.
  task automatic cycle(input bit w, input logic [DW-1:0] wd, input bit r, input bit j);
    bit was_full;
    bit was_empty;
    bus0.winc = w; bus0.wdata = wd; bus0.rinc = r; bus0.jump = j;
    bus1.winc = w; bus1.wdata = wd; bus1.rinc = r; bus1.jump = j;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = '0;
    end else if (j) begin
      mq.delete();
    end else begin
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_rdata = mq.pop_front();
      if (w && !was_full) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
    $display("cyc w=%0b r=%0b j=%0b rst=%0b wd=%h count=%0d rdata=%h", w, r, j, rst, wd,
             bus0.count, bus0.rdata);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, '0, 0, 0);
    cycle(0, '0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus0.count); end
    checks++; if (bus0.rempty !== 1'b1) begin failures++; $display("FAIL reset_rempty got=%0b exp=1", bus0.rempty); end
    checks++; if (bus0.wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%0b exp=0", bus0.wfull); end
    checks++; if (bus0.will_full !== 1'b0) begin failures++; $display("FAIL reset_will_full got=%0b exp=0", bus0.will_full); end
    checks++; if (bus0.almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%0b exp=0", bus0.almost_full); end
    checks++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%0b%0b exp=00", bus0.overflow, bus0.underflow); end
    checks++; if (bus0.rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus0.rdata); end
    checks++; if (bus1.rempty !== 1'b1 || bus1.count !== 3'd0) begin failures++; $display("FAIL reset_fwft got=%0b/%0d exp=1/0", bus1.rempty, bus1.count); end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 64'hA0 + 64'(i);
      cycle(1, v, 0, 0);
      checks++; if (bus0.count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", bus0.count, i + 1); end
      checks++; if (bus0.almost_full !== ((i + 1) >= AF)) begin failures++; $display("FAIL fill_almost_full got=%0b at count %0d", bus0.almost_full, i + 1); end
      checks++; if (bus0.wfull !== ((i + 1) == DEPTH)) begin failures++; $display("FAIL fill_wfull got=%0b at count %0d", bus0.wfull, i + 1); end
      checks++; if (bus0.will_full !== ((i + 1) == DEPTH - 1)) begin failures++; $display("FAIL fill_will_full got=%0b at count %0d", bus0.will_full, i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      v = 64'hA0 + 64'(i);
      cycle(0, '0, 1, 0);
      checks++; if (bus0.rdata !== v) begin failures++; $display("FAIL drain_rdata got=%h exp=%h", bus0.rdata, v); end
      checks++; if (bus0.rempty !== (i == 3)) begin failures++; $display("FAIL drain_rempty got=%0b exp=%0b", bus0.rempty, (i == 3)); end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] vals [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vals[i] = {32'h1000_0000 | 32'($urandom_range(0, 32'h0fff_ffff)), $urandom};
      cycle(1, vals[i], 0, 0);
    end
    cycle(1, 64'hFF, 0, 0);
    checks++; if (bus0.count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", bus0.count); end
    checks++; if (bus0.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", bus0.overflow); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, 0);
      checks++; if (bus0.rdata !== vals[i]) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", bus0.rdata, vals[i]); end
    end
    checks++; if (bus0.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", bus0.overflow); end
    checks++; if (bus0.underflow !== 1'b0) begin failures++; $display("FAIL ovf_no_udf got=%0b exp=0", bus0.underflow); end

    // Underflow follows directly: FIFO empty, last read word was vals[3].
    cycle(0, '0, 1, 0);
    checks++; if (bus0.underflow !== 1'b1) begin failures++; $display("FAIL udf_flag got=%0b exp=1", bus0.underflow); end
    checks++; if (bus0.rdata !== vals[3]) begin failures++; $display("FAIL udf_rdata_hold got=%h exp=%h", bus0.rdata, vals[3]); end
    checks++; if (bus0.count !== 3'd0 || bus0.rempty !== 1'b1) begin failures++; $display("FAIL udf_state got=%0d/%0b exp=0/1", bus0.count, bus0.rempty); end
    cycle(1, 64'h5A5A, 0, 0);
    cycle(0, '0, 1, 0);
    checks++; if (bus0.rdata !== 64'h5A5A) begin failures++; $display("FAIL udf_rdptr got=%h exp=5a5a", bus0.rdata); end
    checks++; if (bus0.underflow !== 1'b1) begin failures++; $display("FAIL udf_sticky got=%0b exp=1", bus0.underflow); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v;
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      v = {$urandom, $urandom};
      exp_q.push_back(v);
      cycle(1, v, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      v = {$urandom, $urandom};
      e = exp_q.pop_front();
      exp_q.push_back(v);
      cycle(1, v, 1, 0);
      checks++; if (bus0.count !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d exp=2", bus0.count); end
      checks++; if (bus0.rdata !== e) begin failures++; $display("FAIL simul_rdata got=%h exp=%h", bus0.rdata, e); end
    end
    cycle(1, 64'h11, 0, 0);
    cycle(1, 64'h22, 0, 0);
    checks++; if (bus0.wfull !== 1'b1) begin failures++; $display("FAIL simul_full got=%0b exp=1", bus0.wfull); end
    cycle(1, 64'h33, 1, 0);
    checks++; if (bus0.count !== 3'd3) begin failures++; $display("FAIL full_wr_rd_count got=%0d exp=3", bus0.count); end
    checks++; if (bus0.overflow !== 1'b1) begin failures++; $display("FAIL full_wr_rd_ovf got=%0b exp=1", bus0.overflow); end
    e = exp_q.pop_front();
    checks++; if (bus0.rdata !== e) begin failures++; $display("FAIL full_wr_rd_rdata got=%h exp=%h", bus0.rdata, e); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 64'h1, 0, 0);
    cycle(1, 64'h2, 0, 0);
    cycle(1, 64'h3, 0, 0);
    cycle(1, 64'h4, 1, 1);
    checks++; if (bus0.count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", bus0.count); end
    checks++; if (bus0.rempty !== 1'b1) begin failures++; $display("FAIL flush_rempty got=%0b exp=1", bus0.rempty); end
    checks++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin failures++; $display("FAIL flush_sticky got=%0b%0b exp=00", bus0.overflow, bus0.underflow); end
    checks++; if (bus0.rdata !== 64'h0) begin failures++; $display("FAIL flush_rdata_hold got=%h exp=0", bus0.rdata); end
    cycle(1, 64'hB0, 0, 0);
    cycle(0, '0, 1, 0);
    checks++; if (bus0.rdata !== 64'hB0) begin failures++; $display("FAIL flush_readback got=%h exp=b0", bus0.rdata); end
    checks++; if (bus0.rempty !== 1'b1) begin failures++; $display("FAIL flush_readback_empty got=%0b exp=1", bus0.rempty); end
  endtask

  task automatic test_fwft();
    do_reset();
    cycle(1, 64'hC0, 0, 0);
    cycle(0, '0, 0, 0);
    checks++; if (bus1.rdata !== 64'hC0) begin failures++; $display("FAIL fwft_rdata got=%h exp=c0", bus1.rdata); end
    checks++; if (bus1.rempty !== 1'b0) begin failures++; $display("FAIL fwft_nonempty got=%0b exp=0", bus1.rempty); end
    cycle(0, '0, 1, 0);
    checks++; if (bus1.rempty !== 1'b1 || bus1.count !== 3'd0) begin failures++; $display("FAIL fwft_pop got=%0b/%0d exp=1/0", bus1.rempty, bus1.count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 64'hD1, 0, 0);
    cycle(1, 64'hD2, 0, 0);
    cycle(1, 64'hD3, 1, 0);
    checks++; if (bus0.count !== 3'd2 || bus0.rdata !== 64'hD1) begin failures++; $display("FAIL rstmid_pre got=%0d/%h exp=2/d1", bus0.count, bus0.rdata); end
    rst = 1'b1;
    cycle(1, 64'hD4, 1, 0);
    rst = 1'b0;
    checks++; if (bus0.count !== 3'd0 || bus0.rempty !== 1'b1) begin failures++; $display("FAIL rstmid_ptrs got=%0d/%0b exp=0/1", bus0.count, bus0.rempty); end
    checks++; if (bus0.wfull !== 1'b0 || bus0.will_full !== 1'b0 || bus0.almost_full !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%0b%0b%0b exp=000", bus0.wfull, bus0.will_full, bus0.almost_full); end
    checks++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin failures++; $display("FAIL rstmid_sticky got=%0b%0b exp=00", bus0.overflow, bus0.underflow); end
    checks++; if (bus0.rdata !== 64'h0) begin failures++; $display("FAIL rstmid_rdata got=%h exp=0", bus0.rdata); end
  endtask

  task automatic test_random();
    bit w;
    bit r;
    bit j;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Alternate write-heavy and read-heavy phases to reach both boundaries.
      if ((i / 40) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      j = ($urandom_range(0, 39) == 0);
      cycle(w, {$urandom, $urandom}, r, j);
      checks++; if (bus0.count !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", bus0.count, mq.size()); end
      checks++; if (bus0.rempty !== (mq.size() == 0) || bus0.wfull !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rnd_empty_full got=%0b%0b size=%0d", bus0.rempty, bus0.wfull, mq.size()); end
      checks++; if (bus0.almost_full !== (mq.size() >= AF) || bus0.will_full !== (mq.size() == DEPTH - 1)) begin failures++; $display("FAIL rnd_af_wf got=%0b%0b size=%0d", bus0.almost_full, bus0.will_full, mq.size()); end
      checks++; if (bus0.overflow !== m_ovf || bus0.underflow !== m_udf) begin failures++; $display("FAIL rnd_sticky got=%0b%0b exp=%0b%0b", bus0.overflow, bus0.underflow, m_ovf, m_udf); end
      checks++; if (bus0.rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata got=%h exp=%h", bus0.rdata, m_rdata); end
      if (mq.size() != 0) begin
        checks++; if (bus1.rdata !== mq[0]) begin failures++; $display("FAIL rnd_fwft_rdata got=%h exp=%h", bus1.rdata, mq[0]); end
      end
    end
  endtask

  initial begin
    bus0.winc = 1'b0; bus0.rinc = 1'b0; bus0.jump = 1'b0; bus0.wdata = '0;
    bus1.winc = 1'b0; bus1.rinc = 1'b0; bus1.jump = 1'b0; bus1.wdata = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_fwft();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
